// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter that shares the single register-file read port among NREQ requesters
// and returns each selected word over a valid/ready response channel.
module regfile_read_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [5*NREQ-1:0]    i_req_addr,
  output logic [NREQ-1:0]      o_req_ready,
  output logic [4:0]           o_mux_sel,
  input  logic [31:0]          i_mux_out,
  output logic                 o_rsp_valid,
  output logic [IDW-1:0]       o_rsp_id,
  output logic [31:0]          o_rsp_data,
  input  logic                 i_rsp_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_rsp_id;
  logic [4:0]     r_mux_sel;
  logic [31:0]    r_rsp_data;
  logic           r_rsp_valid;

  logic            w_can_grant;
  logic            w_found;
  logic [IDW-1:0]  w_grant_idx;
  logic [IDW-1:0]  w_next_ptr;
  logic [4:0]      w_grant_addr;
  logic [NREQ-1:0] w_req_ready;
  logic [4:0]      w_addr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_addr
      assign w_addr[gi] = i_req_addr[5*gi +: 5];
    end
  endgenerate

  function automatic int rr_index(input logic [IDW-1:0] ptr, input int k);
    return (int'(ptr) + k) % NREQ;
  endfunction

  assign w_can_grant = (r_state == S_IDLE) || ((r_state == S_RESP) && i_rsp_ready);

  // Scan from the farthest candidate back to rr_ptr so the nearest requester overwrites the rest.
  always_comb begin
    w_found      = 1'b0;
    w_grant_idx  = '0;
    w_next_ptr   = r_rr_ptr;
    w_grant_addr = '0;
    w_req_ready  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_can_grant && i_req_valid[rr_index(r_rr_ptr, k)]) begin
        w_found      = 1'b1;
        w_grant_idx  = IDW'(rr_index(r_rr_ptr, k));
        w_next_ptr   = IDW'(rr_index(r_rr_ptr, k + 1));
        w_grant_addr = w_addr[rr_index(r_rr_ptr, k)];
        w_req_ready  = '0;
        w_req_ready[rr_index(r_rr_ptr, k)] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_mux_sel   <= '0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      if (w_found) begin
        r_mux_sel <= w_grant_addr;
        r_rsp_id  <= w_grant_idx;
        r_rr_ptr  <= w_next_ptr;
      end
      case (r_state)
        S_IDLE: begin
          if (w_found) r_state <= S_READ;
        end
        S_READ: begin
          r_rsp_data  <= i_mux_out;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= w_found ? S_READ : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready = w_req_ready;
  assign o_mux_sel   = r_mux_sel;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter: reset, single read, round-robin order,
// backpressure, address extremes, reset mid-read and withdrawn requests.
module tb_regfile_read_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [19:0] req_addr;
  logic [3:0]  req_ready;
  logic [4:0]  mux_sel;
  logic [31:0] mux_out;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_ready;

  int cmp_cnt = 0;
  int err_cnt = 0;

  regfile_read_arbiter #(.NREQ(4), .IDW(2)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req_valid (req_valid),
    .i_req_addr  (req_addr),
    .o_req_ready (req_ready),
    .o_mux_sel   (mux_sel),
    .i_mux_out   (mux_out),
    .o_rsp_valid (rsp_valid),
    .o_rsp_id    (rsp_id),
    .o_rsp_data  (rsp_data),
    .i_rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file stand-in: a few fixed words, everything else tagged with its index.
  function automatic logic [31:0] mux_model(input logic [4:0] s);
    if (s == 5'd17) return 32'hDEAD_0011;
    if (s == 5'd0)  return 32'h0000_0000;
    if (s == 5'd31) return 32'hFFFF_FFFF;
    return 32'hA5A5_0000 | {27'd0, s};
  endfunction

  assign mux_out = mux_model(mux_sel);

  always @(negedge clk)
    if (!reset && rsp_valid && rsp_ready)
      $display("rsp id=%0d data=%h", rsp_id, rsp_data);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [4:0] a);
    req_addr[5*i +: 5] = a;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_addr = '0; rsp_ready = 1'b0;
    cyc(); cyc();
    cmp_cnt++; if (mux_sel !== 5'd0) begin err_cnt++; $display("FAIL reset_mux_sel: got %0d want 0", mux_sel); end
    cmp_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    cmp_cnt++; if (rsp_id !== 2'd0) begin err_cnt++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    cmp_cnt++; if (rsp_data !== 32'd0) begin err_cnt++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    cmp_cnt++; if (req_ready !== 4'b0000) begin err_cnt++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    req_valid = 4'b0100; set_addr(2, 5'd17); rsp_ready = 1'b0;
    #1;
    cmp_cnt++; if (req_ready !== 4'b0100) begin err_cnt++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    cyc(); req_valid = '0; #1;
    cmp_cnt++; if (mux_sel !== 5'd17) begin err_cnt++; $display("FAIL single_mux_sel: got %0d want 17", mux_sel); end
    cmp_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL single_early_valid: got %b want 0", rsp_valid); end
    cyc();
    cmp_cnt++; if (rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
    cmp_cnt++; if (rsp_id !== 2'd2) begin err_cnt++; $display("FAIL single_rsp_id: got %0d want 2", rsp_id); end
    cmp_cnt++; if (rsp_data !== 32'hDEAD_0011) begin err_cnt++; $display("FAIL single_rsp_data: got %h want dead0011", rsp_data); end
    rsp_ready = 1'b1;
    cyc(); #1;
    cmp_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL single_rsp_done: got %b want 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    reset = 1'b1; cyc(); reset = 1'b0;
    for (int i = 0; i < 4; i++) set_addr(i, 5'(4 + i));
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      logic [3:0] exp_ready;
      exp_ready = 4'(1 << (g % 4));
      #1;
      cmp_cnt++; if (req_ready !== exp_ready) begin err_cnt++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, exp_ready); end
      cyc();
      if (g == 4) req_valid = '0;
      #1;
      cmp_cnt++; if (mux_sel !== 5'(4 + g % 4)) begin err_cnt++; $display("FAIL rr_mux_sel%0d: got %0d want %0d", g, mux_sel, 4 + g % 4); end
      cmp_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rr_gap%0d: got %b want 0", g, rsp_valid); end
      cyc();
      cmp_cnt++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g % 4)) begin err_cnt++; $display("FAIL rr_rsp%0d: valid=%b id=%0d want valid=1 id=%0d", g, rsp_valid, rsp_id, g % 4); end
      cmp_cnt++; if (rsp_data !== mux_model(5'(4 + g % 4))) begin err_cnt++; $display("FAIL rr_data%0d: got %h want %h", g, rsp_data, mux_model(5'(4 + g % 4))); end
    end
    cyc(); #1;
    cmp_cnt++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin err_cnt++; $display("FAIL rr_idle: valid=%b ready=%b want 0/0000", rsp_valid, req_ready); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0; req_valid = 4'b1000; set_addr(3, 5'd9);
    #1;
    cmp_cnt++; if (req_ready !== 4'b1000) begin err_cnt++; $display("FAIL bp_grant: got %b want 1000", req_ready); end
    cyc(); req_valid = 4'b0001; set_addr(0, 5'd12); #1;
    cmp_cnt++; if (req_ready !== 4'b0000) begin err_cnt++; $display("FAIL bp_read_ready: got %b want 0000", req_ready); end
    cyc();
    for (int c = 0; c < 5; c++) begin
      #1;
      cmp_cnt++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== mux_model(5'd9)) begin err_cnt++; $display("FAIL bp_hold%0d: valid=%b id=%0d data=%h want 1/3/%h", c, rsp_valid, rsp_id, rsp_data, mux_model(5'd9)); end
      cmp_cnt++; if (req_ready !== 4'b0000) begin err_cnt++; $display("FAIL bp_ready%0d: got %b want 0000", c, req_ready); end
      cyc();
    end
    rsp_ready = 1'b1; #1;
    cmp_cnt++; if (req_ready !== 4'b0001) begin err_cnt++; $display("FAIL bp_release_grant: got %b want 0001", req_ready); end
    cyc(); req_valid = '0; #1;
    cmp_cnt++; if (rsp_valid !== 1'b0 || mux_sel !== 5'd12) begin err_cnt++; $display("FAIL bp_next_read: valid=%b sel=%0d want 0/12", rsp_valid, mux_sel); end
    cyc(); #1;
    cmp_cnt++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== mux_model(5'd12)) begin err_cnt++; $display("FAIL bp_next_rsp: valid=%b id=%0d data=%h want 1/0/%h", rsp_valid, rsp_id, rsp_data, mux_model(5'd12)); end
    cyc(); #1;
    cmp_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_idle: got %b want 0", rsp_valid); end
  endtask

  task automatic test_addr_extremes();
    for (int e = 0; e < 2; e++) begin
      logic [4:0]  a;
      logic [31:0] d;
      logic [3:0]  exp_ready;
      a = (e == 0) ? 5'd0 : 5'd31;
      d = (e == 0) ? 32'h0000_0000 : 32'hFFFF_FFFF;
      exp_ready = 4'(1 << (1 + e));
      req_valid = exp_ready; set_addr(1 + e, a);
      #1;
      cmp_cnt++; if (req_ready !== exp_ready) begin err_cnt++; $display("FAIL ext_grant%0d: got %b want %b", e, req_ready, exp_ready); end
      cyc(); req_valid = '0; #1;
      cmp_cnt++; if (mux_sel !== a) begin err_cnt++; $display("FAIL ext_mux_sel%0d: got %0d want %0d", e, mux_sel, a); end
      cyc(); #1;
      cmp_cnt++; if (rsp_data !== d || rsp_id !== 2'(1 + e)) begin err_cnt++; $display("FAIL ext_rsp%0d: data=%h id=%0d want %h/%0d", e, rsp_data, rsp_id, d, 1 + e); end
      cyc(); #1;
    end
    cyc(); #1;
    cmp_cnt++; if (mux_sel !== 5'd31) begin err_cnt++; $display("FAIL ext_sel_held: got %0d want 31", mux_sel); end
  endtask

  task automatic test_reset_mid_read();
    req_valid = 4'b0100; set_addr(2, 5'd3);
    #1;
    cmp_cnt++; if (req_ready !== 4'b0100) begin err_cnt++; $display("FAIL rst_pre_grant: got %b want 0100", req_ready); end
    cyc(); req_valid = '0; #1;
    reset = 1'b1; #1;
    cmp_cnt++; if (mux_sel !== 5'd0 || rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_async: sel=%0d valid=%b want 0/0", mux_sel, rsp_valid); end
    cmp_cnt++; if (rsp_id !== 2'd0 || rsp_data !== 32'd0) begin err_cnt++; $display("FAIL rst_async_rsp: id=%0d data=%h want 0/0", rsp_id, rsp_data); end
    cmp_cnt++; if (req_ready !== 4'b0000) begin err_cnt++; $display("FAIL rst_async_ready: got %b want 0000", req_ready); end
    cyc();
    cmp_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_no_pulse: got %b want 0", rsp_valid); end
    reset = 1'b0;
    req_valid = 4'b1010; set_addr(1, 5'd5); set_addr(3, 5'd6);
    #1;
    cmp_cnt++; if (req_ready !== 4'b0010) begin err_cnt++; $display("FAIL rst_fresh_grant: got %b want 0010", req_ready); end
    cyc(); req_valid = '0;
    cyc(); #1;
    cmp_cnt++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== mux_model(5'd5)) begin err_cnt++; $display("FAIL rst_fresh_rsp: valid=%b id=%0d data=%h want 1/1/%h", rsp_valid, rsp_id, rsp_data, mux_model(5'd5)); end
    cyc(); #1;
  endtask

  task automatic test_withdrawn();
    rsp_ready = 1'b0; req_valid = 4'b0001; set_addr(0, 5'd20);
    #1;
    cmp_cnt++; if (req_ready !== 4'b0001) begin err_cnt++; $display("FAIL wd_grant: got %b want 0001", req_ready); end
    cyc(); req_valid = '0;
    cyc(); req_valid = 4'b1000; set_addr(3, 5'd21); #1;
    cmp_cnt++; if (req_ready !== 4'b0000) begin err_cnt++; $display("FAIL wd_ready_a: got %b want 0000", req_ready); end
    cyc(); #1;
    cmp_cnt++; if (req_ready !== 4'b0000 || rsp_id !== 2'd0 || rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL wd_hold: ready=%b id=%0d valid=%b want 0000/0/1", req_ready, rsp_id, rsp_valid); end
    req_valid = '0;
    cyc(); rsp_ready = 1'b1; #1;
    cmp_cnt++; if (req_ready !== 4'b0000) begin err_cnt++; $display("FAIL wd_release: got %b want 0000", req_ready); end
    cyc(); #1;
    cmp_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL wd_idle: got %b want 0", rsp_valid); end
    req_valid = 4'b1001; #1;
    cmp_cnt++; if (req_ready !== 4'b1000) begin err_cnt++; $display("FAIL wd_ptr_kept: got %b want 1000", req_ready); end
    cyc(); req_valid = '0;
    cyc(); #1;
    cmp_cnt++; if (rsp_id !== 2'd3 || rsp_data !== mux_model(5'd21)) begin err_cnt++; $display("FAIL wd_final_rsp: id=%0d data=%h want 3/%h", rsp_id, rsp_data, mux_model(5'd21)); end
    cyc(); #1;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_backpressure();
    test_addr_extremes();
    test_reset_mid_read();
    test_withdrawn();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
